// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, multi-cycle multiply, memory waits, branch flush.
// Define PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [2:0]       id_rsrc1,
  input  logic [2:0]       id_rsrc2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_rdst,
  input  logic             ex_mul_start,
  input  logic             ex_br_taken,
  input  logic             me_mem_req,
  input  logic             me_mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exme_en,
  output logic             mewb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exme_bubble,
  output logic             mewb_bubble,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned CntW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MUL_CYCLES - 2);

  typedef enum logic [0:0] {StRun, StMulBusy} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic in_run;
  logic mem_wait;
  logic mul_start;
  logic mul_last;
  logic mul_stall;
  logic raw_hit;
  logic load_use;
  logic br_take;

  // Every hazard term is qualified by rst_n so reset decodes as plain RUN.
  always_comb begin
    in_run    = (state_q == StRun);
    mem_wait  = rst_n & me_mem_req & ~me_mem_ready;
    mul_start = rst_n & in_run & ex_valid & ex_mul_start;
    mul_last  = (state_q == StMulBusy) & (cnt_q == '0);
    mul_stall = mul_start | ((state_q == StMulBusy) & (cnt_q != '0));
    raw_hit   = (id_use1 & (id_rsrc1 == ex_rdst)) | (id_use2 & (id_rsrc2 == ex_rdst));
    load_use  = rst_n & in_run & ex_valid & ex_is_load & id_valid & raw_hit;
    br_take   = rst_n & ex_valid & ex_br_taken;
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exme_en     = 1'b1;
    mewb_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exme_bubble = 1'b0;
    mewb_bubble = 1'b0;
    mul_done    = 1'b0;
    mul_busy    = (state_q == StMulBusy);
    if (mem_wait) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exme_en     = 1'b0;
      mewb_en     = 1'b0;
      mewb_bubble = 1'b1;
    end else if (mul_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exme_en     = 1'b0;
      exme_bubble = 1'b1;
    end else begin
      mul_done = mul_last;
      if (br_take) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // A memory wait freezes the multiply sequencer so the operation finishes late, not short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else if (!mem_wait) begin
      case (state_q)
        StRun: begin
          if (ex_valid & ex_mul_start) begin
            state_q <= StMulBusy;
            cnt_q   <= CntLoad;
          end
        end
        StMulBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (ifid_flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
